reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's 4x8 register file: 2**A registers of W bits, three combinational read ports, one clocked write port.
- Keeps the immediate-move path, generalised to any A.
- Adds a per-register busy scoreboard so the control unit can reserve a destination for a multi-cycle result (data memory load) and detect read-after-write hazards.
- Sits between decode and ALU; DataOutA/B/C feed ALU operands, BusyA/B/C feed the stall logic.

Parameters:
- W, 8, data path width; must satisfy W >= 2*A.
- A, 2, address pointer width; depth = 2**A registers.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- WriteEn  in  1  write DataIn to Registers[Waddr].
- MovEn  in  1  immediate move: Registers[Waddr][2A-1:0] <= {RaddrA, RaddrB}.
- RaddrA  in  A  read address A; also the high half of the move immediate.
- RaddrB  in  A  read address B; also the low half of the move immediate.
- RaddrC  in  A  read address C.
- Waddr  in  A  write / move destination.
- DataIn  in  W  write data.
- ReserveEn  in  1  mark Registers[ReserveAddr] busy.
- ReserveAddr  in  A  register to reserve.
- DataOutA  out  W  Registers[RaddrA].
- DataOutB  out  W  Registers[RaddrB].
- DataOutC  out  W  Registers[RaddrC].
- BusyA  out  1  busy bit of RaddrA.
- BusyB  out  1  busy bit of RaddrB.
- BusyC  out  1  busy bit of RaddrC.
- BusyVec  out  2**A  full scoreboard, bit i = register i busy.
- AllBusy  out  1  every register reserved.

Behaviour:
- Reset (Reset_n low, asynchronous assert, release synchronous to Clk):
  - all registers go to 0 and all busy bits go to 0.
  - So DataOutX=0, BusyX=0, BusyVec=0, AllBusy=0 while in reset.
  - Reset mid-reservation discards all pending reservations.
- Reads: purely combinational from the register array, zero latency. Register 0 is an ordinary register, readable and writable.
- Write priority per cycle: WriteEn > MovEn.
  - WriteEn=1: Registers[Waddr] <= DataIn (full W bits).
  - Else MovEn=1: the low 2A bits of Registers[Waddr] take {RaddrA,RaddrB}; bits W-1:2A are unchanged.
  - Neither asserted: no register update.
- Scoreboard, per register i, evaluated each edge:
  - Set: ReserveEn && ReserveAddr==i.
  - Clear: (WriteEn || MovEn) && Waddr==i.
  - Set and clear in the same cycle on the same register: set wins and the bit stays 1 (the old result retires, a new one is pending); the write data still lands.
  - Reserving an already-busy register: no change, stays 1.
  - Writing a non-busy register: the write happens and the bit stays 0.
- BusyX = BusyVec[RaddrX], combinational. AllBusy = &BusyVec.
- The block does not stall itself: writes and reads are never blocked by busy bits. Stalling is the control unit's job.
- All data arithmetic is width-exact; there is no sign extension or truncation beyond the W/2A slicing above.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If WriteEn && Waddr==RaddrX, DataOutX = DataIn in the same cycle.
  - If MovEn (and not WriteEn) && Waddr==RaddrX, DataOutX = {Registers[Waddr][W-1:2A], RaddrA, RaddrB}.
  - BusyX also reflects the same-cycle clear: it is 0 when the forwarded write clears a busy bit and no same-cycle reserve targets that register.
- Not defined: reads return the stored value only; a write is visible on DataOutX the cycle after the edge.

Test Plan:
- Reset: pulse Reset_n low mid-cycle after writing 8'hA5 to r2 -> DataOutA (RaddrA=2) reads 0 immediately, before the next Clk edge; BusyVec=0.
- Write/read: WriteEn, Waddr=1, DataIn=8'h3C; next cycle RaddrA=RaddrB=RaddrC=1 -> all three DataOut read 8'h3C.
- Move immediate: r3=8'hF0, then MovEn, Waddr=3, RaddrA=2'b10, RaddrB=2'b01 -> r3=8'hF9. With WriteEn also high and DataIn=8'h11 -> r3=8'h11.
- Scoreboard: ReserveEn, ReserveAddr=2 -> BusyVec=4'b0100, BusyA=1 when RaddrA=2. A later WriteEn to Waddr=2 -> BusyVec=0. Reserving all four -> AllBusy=1.
- Set/clear collision: r1 busy; same cycle WriteEn Waddr=1 DataIn=8'h77 plus ReserveEn ReserveAddr=1 -> r1=8'h77, BusyVec[1] stays 1.
- Bypass: WriteEn Waddr=0 DataIn=8'h5A, RaddrC=0 in the same cycle -> with REGFILE_BYPASS_EN DataOutC=8'h5A that cycle; without it, old value that cycle and 8'h5A next cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised 2**A x W register file: three combinational read ports, one write/move port, per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int W = 8,
    parameter int A = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             WriteEn,
    input  logic             MovEn,
    input  logic [A-1:0]     RaddrA,
    input  logic [A-1:0]     RaddrB,
    input  logic [A-1:0]     RaddrC,
    input  logic [A-1:0]     Waddr,
    input  logic [W-1:0]     DataIn,
    input  logic             ReserveEn,
    input  logic [A-1:0]     ReserveAddr,
    output logic [W-1:0]     DataOutA,
    output logic [W-1:0]     DataOutB,
    output logic [W-1:0]     DataOutC,
    output logic             BusyA,
    output logic             BusyB,
    output logic             BusyC,
    output logic [2**A-1:0]  BusyVec,
    output logic             AllBusy
);

    localparam int N = 2**A;

    logic [W-1:0] registers [N];
    logic [N-1:0] busy;
    logic [N-1:0] busy_next;
    logic         wr_any;
    logic [W-1:0] wr_val;

    assign wr_any = WriteEn | MovEn;

    // Value that lands in Registers[Waddr] this edge; the move keeps the upper W-2A bits.
    always_comb begin
        wr_val = registers[Waddr];
        if (WriteEn) begin
            wr_val = DataIn;
        end else begin
            wr_val[2*A-1:0] = {RaddrA, RaddrB};
        end
    end

    // Reserve is applied after clear so a same-cycle set on the same register wins.
    always_comb begin
        busy_next = busy;
        if (wr_any) begin
            busy_next[Waddr] = 1'b0;
        end
        if (ReserveEn) begin
            busy_next[ReserveAddr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N; i++) begin
                registers[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_any) begin
                registers[Waddr] <= wr_val;
            end
            busy <= busy_next;
        end
    end

    assign BusyVec = busy;
    assign AllBusy = &busy;

`ifdef REGFILE_BYPASS_EN
    logic fwd_a, fwd_b, fwd_c;
    logic rsv_a, rsv_b, rsv_c;

    assign fwd_a = wr_any && (Waddr == RaddrA);
    assign fwd_b = wr_any && (Waddr == RaddrB);
    assign fwd_c = wr_any && (Waddr == RaddrC);
    assign rsv_a = ReserveEn && (ReserveAddr == RaddrA);
    assign rsv_b = ReserveEn && (ReserveAddr == RaddrB);
    assign rsv_c = ReserveEn && (ReserveAddr == RaddrC);

    assign DataOutA = fwd_a ? wr_val : registers[RaddrA];
    assign DataOutB = fwd_b ? wr_val : registers[RaddrB];
    assign DataOutC = fwd_c ? wr_val : registers[RaddrC];

    // A forwarded write retires the pending result unless a new reservation lands on it too.
    assign BusyA = busy[RaddrA] & ~(fwd_a & ~rsv_a);
    assign BusyB = busy[RaddrB] & ~(fwd_b & ~rsv_b);
    assign BusyC = busy[RaddrC] & ~(fwd_c & ~rsv_c);
`else
    assign DataOutA = registers[RaddrA];
    assign DataOutB = registers[RaddrB];
    assign DataOutC = registers[RaddrC];

    assign BusyA = busy[RaddrA];
    assign BusyB = busy[RaddrB];
    assign BusyC = busy[RaddrC];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (W=8, A=2); expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file_sb;

    localparam int W = 8;
    localparam int A = 2;
    localparam int N = 4;

    logic         Clk;
    logic         Reset_n;
    logic         WriteEn;
    logic         MovEn;
    logic [A-1:0] RaddrA;
    logic [A-1:0] RaddrB;
    logic [A-1:0] RaddrC;
    logic [A-1:0] Waddr;
    logic [W-1:0] DataIn;
    logic         ReserveEn;
    logic [A-1:0] ReserveAddr;
    logic [W-1:0] DataOutA;
    logic [W-1:0] DataOutB;
    logic [W-1:0] DataOutC;
    logic         BusyA;
    logic         BusyB;
    logic         BusyC;
    logic [N-1:0] BusyVec;
    logic         AllBusy;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;
    int checks;
    int errors;

    reg_file_sb #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .WriteEn(WriteEn), .MovEn(MovEn),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .RaddrC(RaddrC), .Waddr(Waddr),
        .DataIn(DataIn), .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .DataOutA(DataOutA), .DataOutB(DataOutB), .DataOutC(DataOutC),
        .BusyA(BusyA), .BusyB(BusyB), .BusyC(BusyC),
        .BusyVec(BusyVec), .AllBusy(AllBusy)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WriteEn   = 1'b0;
        MovEn     = 1'b0;
        ReserveEn = 1'b0;
    endtask

    task automatic drive_write(input logic [A-1:0] wa, input logic [W-1:0] d);
        WriteEn = 1'b1;
        Waddr   = wa;
        DataIn  = d;
    endtask

    task automatic drive_reserve(input logic [A-1:0] ra);
        ReserveEn   = 1'b1;
        ReserveAddr = ra;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle();
        RaddrA = 2'd0; RaddrB = 2'd1; RaddrC = 2'd2;
        Waddr = '0; DataIn = '0; ReserveAddr = '0;
        #12;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutA !== exp || DataOutB !== exp || DataOutC !== exp) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected %h", DataOutA, DataOutB, DataOutC, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({3'b0, AllBusy, BusyVec} !== exp || {BusyA, BusyB, BusyC} !== 3'b000) begin
            errors++;
            $display("FAIL reset_busy: got allbusy=%b vec=%b busy=%b%b%b expected 0", AllBusy, BusyVec, BusyA, BusyB, BusyC);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        // Write r2 and reserve r3, then assert reset mid-cycle
        drive_write(2'd2, 8'hA5);
        drive_reserve(2'd3);
        step();
        idle();
        RaddrA = 2'd2;
        #1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutA !== exp) begin
            errors++;
            $display("FAIL pre_reset_write: got %h expected %h", DataOutA, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({4'b0, BusyVec} !== exp) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b expected %b", BusyVec, exp[3:0]);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutA !== exp) begin
            errors++;
            $display("FAIL async_reset_data: got %h expected %h", DataOutA, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({4'b0, BusyVec} !== exp || AllBusy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_busy: got %b expected %b", BusyVec, exp[3:0]);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        drive_write(2'd1, 8'h3C);
        step();
        idle();
        RaddrA = 2'd1; RaddrB = 2'd1; RaddrC = 2'd1;
        #1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutA !== exp) begin
            errors++;
            $display("FAIL write_read_a: got %h expected %h", DataOutA, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if (DataOutB !== exp) begin
            errors++;
            $display("FAIL write_read_b: got %h expected %h", DataOutB, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp) begin
            errors++;
            $display("FAIL write_read_c: got %h expected %h", DataOutC, exp);
        end
    endtask

    task automatic test_move();
        drive_write(2'd3, 8'hF0);
        step();
        idle();
        MovEn = 1'b1; Waddr = 2'd3; RaddrA = 2'b10; RaddrB = 2'b01;
        step();
        idle();
        RaddrC = 2'd3;
        #1;
        exp_q.push_back(8'hF9);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp) begin
            errors++;
            $display("FAIL move_imm: got %h expected %h", DataOutC, exp);
        end
        // WriteEn takes priority over MovEn
        WriteEn = 1'b1; MovEn = 1'b1; Waddr = 2'd3; DataIn = 8'h11;
        RaddrA = 2'b10; RaddrB = 2'b01; RaddrC = 2'd2;
        step();
        idle();
        RaddrC = 2'd3;
        #1;
        exp_q.push_back(8'h11);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp) begin
            errors++;
            $display("FAIL move_priority: got %h expected %h", DataOutC, exp);
        end
    endtask

    task automatic test_scoreboard();
        drive_reserve(2'd2);
        step();
        idle();
        RaddrA = 2'd2; RaddrB = 2'd1;
        #1;
        exp_q.push_back(8'h04);
        exp = exp_q.pop_front();
        checks++;
        if ({4'b0, BusyVec} !== exp || BusyA !== 1'b1 || BusyB !== 1'b0 || AllBusy !== 1'b0) begin
            errors++;
            $display("FAIL reserve_r2: got vec=%b a=%b b=%b all=%b expected vec=%b a=1 b=0 all=0", BusyVec, BusyA, BusyB, AllBusy, exp[3:0]);
        end
        drive_write(2'd2, 8'h42);
        step();
        idle();
        #1;
        exp_q.push_back(8'h00);
        exp = exp_q.pop_front();
        checks++;
        if ({4'b0, BusyVec} !== exp || DataOutA !== 8'h42) begin
            errors++;
            $display("FAIL write_clears: got vec=%b data=%h expected vec=%b data=42", BusyVec, DataOutA, exp[3:0]);
        end
        for (int i = 0; i < N; i++) begin
            drive_reserve(i[A-1:0]);
            step();
        end
        idle();
        #1;
        checks++;
        if (AllBusy !== 1'b1 || BusyVec !== 4'hF) begin
            errors++;
            $display("FAIL all_busy: got all=%b vec=%b expected all=1 vec=1111", AllBusy, BusyVec);
        end
        // Re-reserve busy r1 alongside a move to r0 (immediate {01,10})
        drive_reserve(2'd1);
        MovEn = 1'b1; Waddr = 2'd0; RaddrA = 2'd1; RaddrB = 2'd2;
        step();
        idle();
        RaddrC = 2'd0;
        #1;
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'h06);
        exp = exp_q.pop_front();
        checks++;
        if ({4'b0, BusyVec} !== exp || AllBusy !== 1'b0 || BusyC !== 1'b0) begin
            errors++;
            $display("FAIL move_clears: got vec=%b all=%b c=%b expected vec=%b all=0 c=0", BusyVec, AllBusy, BusyC, exp[3:0]);
        end
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp) begin
            errors++;
            $display("FAIL move_r0: got %h expected %h", DataOutC, exp);
        end
        drive_write(2'd0, 8'hC3);
        step();
        idle();
        #1;
        checks++;
        if (BusyVec !== 4'hE || DataOutC !== 8'hC3) begin
            errors++;
            $display("FAIL write_nonbusy: got vec=%b data=%h expected vec=1110 data=c3", BusyVec, DataOutC);
        end
    endtask

    task automatic test_collision();
        drive_write(2'd1, 8'h77);
        drive_reserve(2'd1);
        step();
        idle();
        RaddrA = 2'd1;
        #1;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h0E);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutA !== exp) begin
            errors++;
            $display("FAIL collision_data: got %h expected %h", DataOutA, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({4'b0, BusyVec} !== exp || BusyA !== 1'b1) begin
            errors++;
            $display("FAIL collision_busy: got vec=%b a=%b expected vec=%b a=1", BusyVec, BusyA, exp[3:0]);
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] exp_c;
        logic         exp_busy_a;
        drive_write(2'd0, 8'h21);
        drive_reserve(2'd0);
        step();
        idle();
        drive_write(2'd0, 8'h5A);
        RaddrA = 2'd0; RaddrB = 2'd3; RaddrC = 2'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_c = 8'h5A;
        exp_busy_a = 1'b0;
`else
        exp_c = 8'h21;
        exp_busy_a = 1'b1;
`endif
        exp_q.push_back(exp_c);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp || BusyA !== exp_busy_a) begin
            errors++;
            $display("FAIL bypass_same_cycle: got data=%h busy=%b expected data=%h busy=%b", DataOutC, BusyA, exp, exp_busy_a);
        end
        step();
        idle();
        #1;
        exp_q.push_back(8'h5A);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp || BusyA !== 1'b0) begin
            errors++;
            $display("FAIL bypass_next_cycle: got data=%h busy=%b expected data=%h busy=0", DataOutC, BusyA, exp);
        end
        // Move forwarding keeps upper nibble of r0 (5) with immediate {01,11}
        MovEn = 1'b1; Waddr = 2'd0; RaddrA = 2'd1; RaddrB = 2'd3; RaddrC = 2'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_c = 8'h57;
`else
        exp_c = 8'h5A;
`endif
        exp_q.push_back(exp_c);
        exp = exp_q.pop_front();
        checks++;
        if (DataOutC !== exp) begin
            errors++;
            $display("FAIL bypass_move: got %h expected %h", DataOutC, exp);
        end
        step();
        idle();
    endtask

    task automatic test_random();
        logic [W-1:0] m [N];
        logic [N-1:0] mb;
        logic [N-1:0] nb;
        logic [A-1:0] wa, ra, rb, rs;
        logic [W-1:0] d;
        logic         we, me, re;
        for (int i = 0; i < N; i++) begin
            m[i] = W'($urandom_range(0, 255));
            drive_write(i[A-1:0], m[i]);
            step();
        end
        idle();
        mb = '0;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            me = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = A'($urandom_range(0, N-1));
            ra = A'($urandom_range(0, N-1));
            rb = A'($urandom_range(0, N-1));
            rs = A'($urandom_range(0, N-1));
            d  = W'($urandom_range(0, 255));
            WriteEn = we; MovEn = me; ReserveEn = re;
            Waddr = wa; RaddrA = ra; RaddrB = rb; DataIn = d; ReserveAddr = rs;
            nb = mb;
            if (we || me) nb[wa] = 1'b0;
            if (re) nb[rs] = 1'b1;
            step();
            if (we) m[wa] = d;
            else if (me) m[wa][3:0] = {ra, rb};
            mb = nb;
            idle();
            RaddrA = A'($urandom_range(0, N-1));
            RaddrB = A'($urandom_range(0, N-1));
            RaddrC = A'($urandom_range(0, N-1));
            #1;
            exp_q.push_back(m[RaddrA]);
            exp_q.push_back(m[RaddrB]);
            exp_q.push_back(m[RaddrC]);
            exp_q.push_back({4'b0, mb});
            exp = exp_q.pop_front();
            checks++;
            if (DataOutA !== exp) begin
                errors++;
                $display("FAIL rand_a[%0d]: got %h expected %h", n, DataOutA, exp);
            end
            exp = exp_q.pop_front();
            checks++;
            if (DataOutB !== exp) begin
                errors++;
                $display("FAIL rand_b[%0d]: got %h expected %h", n, DataOutB, exp);
            end
            exp = exp_q.pop_front();
            checks++;
            if (DataOutC !== exp) begin
                errors++;
                $display("FAIL rand_c[%0d]: got %h expected %h", n, DataOutC, exp);
            end
            exp = exp_q.pop_front();
            checks++;
            if ({4'b0, BusyVec} !== exp || AllBusy !== (&mb) || BusyA !== mb[RaddrA] || BusyC !== mb[RaddrC]) begin
                errors++;
                $display("FAIL rand_busy[%0d]: got vec=%b all=%b a=%b c=%b expected vec=%b", n, BusyVec, AllBusy, BusyA, BusyC, exp[3:0]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_move();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
